// File: rtl/aes_pkg.sv
// Shared AES core definitions: block size, byte type and the SubBytes
// sequencer state encoding.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SUB   = 2'd2,
    DRAIN = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sub_bytes.sv
// Combinational FIPS-197 forward S-box, one byte in, one byte out.
// This is the only S-box in the core; the sequencer time-shares it.
module sub_bytes (
  input  logic [7:0] in_data,
  output logic [7:0] out_data
);

  // Row r, column c holds S(r*16 + c).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_data = SBOX[in_data];

endmodule

// File: rtl/aes_subbytes_seq.sv
// Byte-serial SubBytes stage: load a block, substitute it in place through
// the single shared S-box one byte per cycle, then stream it back out.
module aes_subbytes_seq
  import aes_pkg::*;
#(
  parameter  int NUM_BYTES = AES_BLOCK_BYTES,
  localparam int CNT_W     = $clog2(NUM_BYTES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  aes_byte_t        data_buf [NUM_BYTES];
  logic             buf_we;
  aes_byte_t        buf_wdata;
  aes_byte_t        sbox_in;
  aes_byte_t        sbox_out;
  logic             in_fire;
  logic             out_fire;

  // in_ready is also gated by rst_n so it reads 0 for the whole reset window.
  assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == LOAD));
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign sbox_in   = data_buf[cnt_q];
  assign out_data  = out_valid ? data_buf[cnt_q] : 8'h00;

  sub_bytes u_sub_bytes (
    .in_data  (sbox_in),
    .out_data (sbox_out)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = in_data;

    if (soft_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            buf_we  = 1'b1;
            cnt_d   = CNT_ONE;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            buf_we = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = SUB;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        SUB: begin
          // In-place substitution; the S-box reads the same slot it writes.
          buf_we    = 1'b1;
          buf_wdata = sbox_out;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Block storage carries no reset; its contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      data_buf[cnt_q] <= buf_wdata;
    end
  end

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Scoreboard bench for aes_subbytes_seq: expected S-box bytes are queued on
// input acceptance and compared as the output stream is accepted.
module tb_aes_subbytes_seq;

  logic       clk;
  logic       rst_n;
  logic       soft_clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int         compared;
  int         mismatched;
  int         edge_cnt;
  int         done_cnt;
  int         last_acc_edge;
  logic [7:0] sb_q [$];
  logic [7:0] stim_in  [16];
  logic [7:0] stim_exp [16];

  aes_subbytes_seq #(.NUM_BYTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .soft_clr  (soft_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed stim_in[0..n-1]; on each acceptance optionally queue stim_exp[i].
  task automatic applyStimulus(input int n, input bit gaps, input bit push_exp);
    for (int i = 0; i < n; i++) begin
      bit accepted = 1'b0;
      int guard = 0;
      while (!accepted && guard < 100) begin
        in_data  = stim_in[i];
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        accepted = in_valid && in_ready;
        tick();
        guard++;
      end
      checkOutput("in_accept", 32'(accepted), 32'd1);
      if (accepted) begin
        last_acc_edge = edge_cnt;
        if (push_exp) sb_q.push_back(stim_exp[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  // Accept n output bytes, checking data order, AXI hold and in_ready in DRAIN.
  task automatic drainOutput(input int n, input bit rand_ready, input bit check_lat);
    int         got = 0;
    int         guard = 0;
    bit         hold_pending = 1'b0;
    bit         seen_valid = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_byte;
    while (got < n && guard < 600) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(held));
      end
      if (out_valid) begin
        if (!seen_valid && check_lat) begin
          // Edges counted inclusively from the accepting edge E to E+16.
          checkOutput("latency_edges", 32'(edge_cnt - last_acc_edge + 1), 32'd17);
        end
        seen_valid = 1'b1;
        checkOutput("in_ready_drain", 32'(in_ready), 32'd0);
        if (out_ready) begin
          checkOutput("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          exp_byte = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
          checkOutput("out_data", 32'(out_data), 32'(exp_byte));
          got++;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held = out_data;
        end
      end else begin
        hold_pending = 1'b0;
      end
      tick();
      guard++;
    end
    checkOutput("drain_count", 32'(got), 32'(n));
    out_ready = 1'b0;
  endtask

  initial begin
    int done_before;
    compared   = 0;
    mismatched = 0;
    edge_cnt   = 0;
    done_cnt   = 0;
    last_acc_edge = 0;
    rst_n      = 1'b0;
    soft_clr   = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    out_ready  = 1'b0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);

    // FIPS-197 round-1 SubBytes vector, back-to-back
    stim_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                 8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    stim_exp = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                 8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    done_before = done_cnt;
    applyStimulus(16, 1'b0, 1'b1);
    checkOutput("sub_in_ready", 32'(in_ready), 32'd0);
    checkOutput("sub_busy", 32'(busy), 32'd1);
    drainOutput(16, 1'b0, 1'b1);
    checkOutput("fips_done_now", 32'(done), 32'd1);
    checkOutput("fips_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("fips_done_clear", 32'(done), 32'd0);
    tick();
    checkOutput("fips_done_count", 32'(done_cnt - done_before), 32'd1);

    // Corner S-box bytes with random gaps and backpressure
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: begin stim_in[i] = 8'h00; stim_exp[i] = 8'h63; end
        1: begin stim_in[i] = 8'h01; stim_exp[i] = 8'h7c; end
        2: begin stim_in[i] = 8'h53; stim_exp[i] = 8'hed; end
        default: begin stim_in[i] = 8'hff; stim_exp[i] = 8'h16; end
      endcase
    end
    done_before = done_cnt;
    applyStimulus(16, 1'b1, 1'b1);
    drainOutput(16, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("corner_done_count", 32'(done_cnt - done_before), 32'd1);

    // in_valid held high through SUB and DRAIN must not be captured
    stim_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f};
    stim_exp = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
                 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76};
    applyStimulus(16, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'haa;
    for (int i = 0; i < 4; i++) begin
      checkOutput("phantom_in_ready_sub", 32'(in_ready), 32'd0);
      tick();
    end
    drainOutput(16, 1'b0, 1'b0);
    in_valid = 1'b0;
    stim_in  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                 8'h18, 8'h19, 8'h1a, 8'h1b, 8'h1c, 8'h1d, 8'h1e, 8'h1f};
    stim_exp = '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
                 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0};
    applyStimulus(16, 1'b0, 1'b1);
    drainOutput(16, 1'b0, 1'b0);
    repeat (2) tick();

    // soft_clr while loading byte 7, then a fresh all-zero block
    for (int i = 0; i < 16; i++) stim_in[i] = 8'h5a;
    applyStimulus(7, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5a;
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_busy", 32'(busy), 32'd0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
    checkOutput("clr_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      stim_in[i]  = 8'h00;
      stim_exp[i] = 8'h63;
    end
    done_before = done_cnt;
    applyStimulus(16, 1'b0, 1'b1);
    drainOutput(16, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("clr_done_count", 32'(done_cnt - done_before), 32'd1);

    // Asynchronous reset in the middle of DRAIN
    for (int i = 0; i < 16; i++) begin
      stim_in[i]  = 8'h19;
      stim_exp[i] = 8'hd4;
    end
    applyStimulus(16, 1'b0, 1'b1);
    drainOutput(5, 1'b0, 1'b0);
    checkOutput("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_out_data", 32'(out_data), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      stim_in[i]  = 8'h53;
      stim_exp[i] = 8'hed;
    end
    applyStimulus(16, 1'b0, 1'b1);
    drainOutput(16, 1'b0, 1'b0);
    repeat (2) tick();
    checkOutput("sb_leftover", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
